// File: rtl/uart_rx_ctrl.sv
// UART byte receiver: 8N1 frames sampled mid-bit, delivered through a single-entry valid/ack register.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx_ctrl #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned BIT_TMR_MAX = CLK_FREQ / BAUD;
  localparam int unsigned TmrW        = (BIT_TMR_MAX > 1) ? $clog2(BIT_TMR_MAX) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(BIT_TMR_MAX - 1);
  localparam logic [TmrW-1:0] TmrHalf = TmrW'(BIT_TMR_MAX / 2 - 1);

  if (BIT_TMR_MAX < 4) begin : g_tmr_check
    $error("uart_rx_ctrl: CLK_FREQ/BAUD must be at least 4");
  end

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StStop   = 3'd3,
`ifdef UART_RX_PARITY_EN
    StParity = 3'd5,
`endif
    StBreak  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q;
  logic            valid_q, frame_err_q, overrun_q;
  logic            stop_ok, stop_bad, byte_done;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, parity_err_q;
`endif

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    unique case (state_q)
      StIdle: begin
        tmr_d     = '0;
        bit_idx_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (tmr_q == TmrHalf) begin
          tmr_d   = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (tmr_q == TmrLast) begin
          tmr_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tmr_q == TmrLast) begin
          tmr_d     = '0;
          par_bad_d = rx_s_q ^ (^shift_q);
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (tmr_q == TmrLast) begin
          tmr_d = '0;
          if (rx_s_q) begin
            stop_ok = 1'b1;
            state_d = StIdle;
          end else begin
            stop_bad = 1'b1;
            state_d  = StBreak;
          end
        end
      end
      StBreak: begin
        tmr_d = '0;
        if (rx_s_q) state_d = StIdle;
      end
      default: begin
        tmr_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign byte_done = stop_ok & ~par_bad_q;
`else
  assign byte_done = stop_ok;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      tmr_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= uart_rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= stop_bad;
      // A new byte overwrites an unconsumed one unless it is taken this very cycle.
      overrun_q   <= byte_done & valid_q & ~ack;
      if (byte_done) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (ack) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= stop_ok & par_bad_q;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
